// File: rtl/mem_io_bridge.sv
// Bridge between the CPU load/store datapath and Data-Memory plus memory-mapped IO channels.
// Registered output channels with strobes, synchronised inputs, stalled multi-cycle reads, sticky error.
module mem_io_bridge #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int          N_OUT   = 4,
  parameter int          N_IN    = 4,
  parameter int          IO_W    = 16,
  parameter int          MEM_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mRead,
  input  logic                  mWrite,
  input  logic                  ioRead,
  input  logic                  ioWrite,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           r_rdata,
  input  logic [31:0]           m_rdata,
  input  logic [N_IN*IO_W-1:0]  io_in,
  output logic [31:0]           addr_out,
  output logic                  m_wen,
  output logic [31:0]           m_wdata,
  output logic [31:0]           r_wdata,
  output logic                  rdata_valid,
  output logic                  stall,
  output logic [N_OUT*IO_W-1:0] io_out,
  output logic [N_OUT-1:0]      io_strobe,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic [31:0]         rd_q;
  logic                latch;
  logic [N_IN*IO_W-1:0] sync1, sync2;
  logic [29:0]         idx;
  logic                in_win, out_hit, in_hit;
  logic                io_wr_ok, err_set;
  logic [IO_W-1:0]     in_chan;
  logic [31:0]         in_ext;

  // Word index relative to the IO window; IO_BASE is word aligned.
  assign idx     = addr_in[31:2] - IO_BASE[31:2];
  assign in_win  = (addr_in >= IO_BASE);
  assign out_hit = in_win && (idx < 30'(N_OUT));
  assign in_hit  = in_win && (idx >= 30'd16) && (idx < 30'(16 + N_IN));

  assign addr_out  = addr_in;
  assign m_wen     = mWrite & ~ioWrite;
  assign m_wdata   = m_wen ? r_rdata : 32'h0;
  assign dbg_state = state;

  assign io_wr_ok = ioWrite & ~mWrite & out_hit;
  assign err_set  = (mRead & ioRead) | (mWrite & ioWrite)
                  | (ioWrite & ~mWrite & ~out_hit)
                  | (ioRead & ~mRead & ~in_hit);

  always_comb begin
    in_chan = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (idx == 30'(16 + k)) in_chan = sync2[k*IO_W +: IO_W];
    end
    in_ext = '0;
    in_ext[IO_W-1:0] = in_chan;
  end

  // Handshake: stall high means the controller must hold mRead/addr_in and freeze the PC;
  // r_wdata is meaningful only in a cycle where rdata_valid is high, and is 0 otherwise.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    latch       = 1'b0;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    r_wdata     = 32'h0;
    case (state)
      IDLE: begin
        if (MEM_LAT != 0 && mRead && !ioRead) begin
          stall   = 1'b1;
          state_n = WAIT;
          cnt_n   = 3'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 3'd0) begin
          latch   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      DONE: begin
        rdata_valid = 1'b1;
        r_wdata     = rd_q;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state == IDLE && !stall && !(mRead && ioRead)) begin
      if (ioRead) begin
        rdata_valid = 1'b1;
        r_wdata     = in_hit ? in_ext : 32'h0;
      end else if (mRead && MEM_LAT == 0) begin
        rdata_valid = 1'b1;
        r_wdata     = m_rdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rd_q      <= 32'h0;
      sync1     <= '0;
      sync2     <= '0;
      io_out    <= '0;
      io_strobe <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sync1     <= io_in;
      sync2     <= sync1;
      io_strobe <= '0;
      if (latch) rd_q <= m_rdata;
      for (int k = 0; k < N_OUT; k++) begin
        if (io_wr_ok && idx == 30'(k)) begin
          io_out[k*IO_W +: IO_W] <= r_rdata[IO_W-1:0];
          io_strobe[k]           <= 1'b1;
        end
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed literal checks plus random traffic compared every cycle
// against a cycle-count based behavioural model.
module tb_mem_io_bridge;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam int NO = 4;
  localparam int NI = 4;
  localparam int L  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mRead = 1'b0, mWrite = 1'b0, ioRead = 1'b0, ioWrite = 1'b0;
  logic [31:0] addr_in = '0, r_rdata = '0, m_rdata = '0;
  logic [63:0] io_in = '0;
  logic [31:0] addr_out, m_wdata, r_wdata;
  logic        m_wen, rdata_valid, stall, err;
  logic [63:0] io_out;
  logic [3:0]  io_strobe;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_io_bridge #(.IO_BASE(BASE), .N_OUT(NO), .N_IN(NI), .IO_W(16), .MEM_LAT(L)) dut (
    .clock(clock), .reset(reset), .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead),
    .ioWrite(ioWrite), .addr_in(addr_in), .r_rdata(r_rdata), .m_rdata(m_rdata),
    .io_in(io_in), .addr_out(addr_out), .m_wen(m_wen), .m_wdata(m_wdata),
    .r_wdata(r_wdata), .rdata_valid(rdata_valid), .stall(stall), .io_out(io_out),
    .io_strobe(io_strobe), .err(err), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic mr, input logic mw, input logic ir, input logic iw,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] md);
    mRead = mr; mWrite = mw; ioRead = ir; ioWrite = iw;
    addr_in = a; r_rdata = d; m_rdata = md;
  endtask

  // Behavioural model: a read started in cycle t stalls through t+L and returns in t+L+1.
  int          cyc = 0;
  int          rd_start = -1;
  logic [31:0] rd_data = '0;
  logic [15:0] m_out [NO];
  logic [3:0]  m_strb = '0;
  logic        m_err = 1'b0;
  logic [63:0] s1 = '0, s2 = '0;

  initial for (int i = 0; i < NO; i++) m_out[i] = '0;

  always @(negedge clock) begin
    logic        e_stall, e_valid, busy, out_ok, in_ok;
    logic [31:0] e_rd;
    longint      idx;
    idx     = (addr_in >= BASE) ? (longint'(addr_in) - longint'(BASE)) / 4 : -1;
    out_ok  = (idx >= 0) && (idx < NO);
    in_ok   = (idx >= 16) && (idx < 16 + NI);
    busy    = (rd_start >= 0);
    e_stall = 1'b0; e_valid = 1'b0; e_rd = '0;
    if (busy) begin
      if (cyc <= rd_start + L) e_stall = 1'b1;
      else begin e_valid = 1'b1; e_rd = rd_data; end
    end else if (mRead && ioRead) begin
      e_rd = '0;
    end else if (ioRead) begin
      e_valid = 1'b1;
      if (in_ok) e_rd = {16'h0, s2[int'(idx - 16) * 16 +: 16]};
    end else if (mRead) begin
      e_stall = 1'b1;
    end
    if (!reset) begin
      chk("addr_out", addr_out, addr_in);
      chk("m_wen", m_wen, mWrite && !ioWrite);
      chk("m_wdata", m_wdata, (mWrite && !ioWrite) ? r_rdata : 32'h0);
      chk("stall", stall, e_stall);
      chk("rdata_valid", rdata_valid, e_valid);
      chk("r_wdata", r_wdata, e_rd);
      chk("io_out", io_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
      chk("io_strobe", io_strobe, m_strb);
      chk("err", err, m_err);
      chk("fsm_idle", dbg_state == 2'd0, !busy);
    end
    if (reset) begin
      rd_start = -1;
      m_strb = '0;
      m_err = 1'b0;
      for (int i = 0; i < NO; i++) m_out[i] = '0;
      s1 = '0; s2 = '0;
    end else begin
      if (busy) begin
        if (cyc == rd_start + L) rd_data = m_rdata;
        if (cyc == rd_start + L + 1) rd_start = -1;
      end else if (mRead && !ioRead) begin
        rd_start = cyc;
      end
      m_strb = '0;
      if (ioWrite && !mWrite && out_ok) begin
        m_out[int'(idx)] = r_rdata[15:0];
        m_strb[int'(idx)] = 1'b1;
      end
      if ((mRead && ioRead) || (mWrite && ioWrite) || (ioWrite && !mWrite && !out_ok) ||
          (ioRead && !mRead && !in_ok)) m_err = 1'b1;
      s2 = s1;
      s1 = io_in;
    end
    cyc++;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: bench did not reach its end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int op, sel, hold;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("lit_rst_io_out", io_out, 64'h0);
    chk("lit_rst_err", err, 1'b0);
    chk("lit_rst_stall", stall, 1'b0);
    chk("lit_rst_valid", rdata_valid, 1'b0);
    chk("lit_rst_strobe", io_strobe, 4'h0);

    tick(); set_in(0, 0, 0, 1, BASE + 8, 32'hABCD_1234, 0);
    tick(); set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("lit_wr_io_out", io_out, 64'h0000_1234_0000_0000);
    chk("lit_wr_strobe", io_strobe, 4'b0100);
    tick(); io_in = 64'h0000_0000_00F5_0000;
    @(negedge clock);
    chk("lit_strobe_clear", io_strobe, 4'b0000);
    tick();
    tick(); set_in(0, 0, 1, 0, BASE + 16*4 + 4, 0, 0);
    @(negedge clock);
    chk("lit_rd_io_data", r_wdata, 32'h0000_00F5);
    chk("lit_rd_io_valid", rdata_valid, 1'b1);
    chk("lit_rd_io_stall", stall, 1'b0);

    tick(); set_in(1, 0, 0, 0, 32'h0000_0100, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("lit_mrd_stall", stall, 1'b1);
      tick();
    end
    @(negedge clock);
    chk("lit_mrd_data", r_wdata, 32'hDEAD_BEEF);
    chk("lit_mrd_valid", rdata_valid, 1'b1);
    chk("lit_mrd_nostall", stall, 1'b0);
    tick(); set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("lit_mrd_idle", dbg_state, 2'd0);
    chk("lit_mrd_after_valid", rdata_valid, 1'b0);

    tick(); set_in(0, 1, 0, 0, 32'h40, 32'h1357_9BDF, 0);
    @(negedge clock);
    chk("lit_mwr_wen", m_wen, 1'b1);
    chk("lit_mwr_data", m_wdata, 32'h1357_9BDF);
    tick(); set_in(0, 0, 0, 0, 32'h40, 32'h1357_9BDF, 0);
    @(negedge clock);
    chk("lit_mwr_wen_off", m_wen, 1'b0);
    chk("lit_mwr_data_off", m_wdata, 32'h0);
    chk("lit_err_clean", err, 1'b0);

    tick(); set_in(0, 0, 0, 1, BASE + 4*NO, 32'hFFFF_FFFF, 0);
    tick(); set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("lit_oob_err", err, 1'b1);
    chk("lit_oob_io_out", io_out, 64'h0000_1234_0000_0000);
    chk("lit_oob_strobe", io_strobe, 4'h0);
    tick(); set_in(0, 1, 0, 1, BASE, 32'h5555_AAAA, 0);
    @(negedge clock);
    chk("lit_conf_wen", m_wen, 1'b0);
    tick(); set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("lit_conf_strobe", io_strobe, 4'h0);
    chk("lit_conf_io_out", io_out, 64'h0000_1234_0000_0000);
    chk("lit_err_sticky", err, 1'b1);

    for (int n = 0; n < 400; n++) begin
      tick();
      io_in = {$urandom, $urandom};
      op = $urandom_range(0, 9);
      sel = $urandom_range(0, 2);
      case (op)
        0: set_in(0, 0, 0, 0, $urandom, $urandom, $urandom);
        1: set_in(0, 1, 0, 0, $urandom, $urandom, $urandom);
        2, 3: set_in(0, 0, 0, 1, BASE + 4*$urandom_range(0, NO-1), $urandom, $urandom);
        4: set_in(0, 0, 0, 1, (sel == 0) ? BASE + 4*$urandom_range(NO, 15) :
                              (sel == 1) ? BASE - 4*$urandom_range(1, 8) :
                                           BASE + 4*$urandom_range(16, 19), $urandom, $urandom);
        5, 6: set_in(0, 0, 1, 0, BASE + 4*$urandom_range(16, 16+NI-1), $urandom, $urandom);
        7: set_in(0, 0, 1, 0, (sel == 0) ? BASE + 4*$urandom_range(0, 15) :
                              (sel == 1) ? BASE - 4*$urandom_range(1, 8) :
                                           BASE + 4*$urandom_range(16+NI, 200), $urandom, $urandom);
        8: begin
          hold = L + $urandom_range(1, 2);
          set_in(1, 0, 0, 0, $urandom & 32'h0000_FFFC, $urandom, $urandom);
          for (int h = 1; h < hold; h++) begin
            tick();
            m_rdata = $urandom;
            io_in = {$urandom, $urandom};
          end
        end
        default: if (sel == 0) set_in(1, 0, 1, 0, BASE + 4*16, $urandom, $urandom);
                 else set_in(0, 1, 0, 1, BASE, $urandom, $urandom);
      endcase
    end

    tick(); set_in(0, 0, 0, 0, 0, 0, 0);
    tick(); set_in(1, 0, 0, 0, 32'h80, 0, 32'h1111_2222);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("lit_midrst_stall", stall, 1'b0);
    chk("lit_midrst_valid", rdata_valid, 1'b0);
    chk("lit_midrst_io_out", io_out, 64'h0);
    chk("lit_midrst_err", err, 1'b0);
    chk("lit_midrst_idle", dbg_state, 2'd0);
    tick(); tick();
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
